// File: rtl/mask_proc_pkg.sv
// Shared op-code constants and op type for the mask processor and its per-channel lanes.
package mask_proc_pkg;

    typedef logic [3:0] op_t;

    localparam op_t OP_AND    = 4'd0;
    localparam op_t OP_OR     = 4'd1;
    localparam op_t OP_XOR    = 4'd2;
    localparam op_t OP_NOT    = 4'd3;
    localparam op_t OP_GATE   = 4'd4;
    localparam op_t OP_GATE_M = 4'd5;
    localparam op_t OP_THRESH = 4'd6;
    localparam op_t OP_BLEND  = 4'd7;
    localparam op_t OP_ADDS   = 4'd8;
    localparam op_t OP_SUBS   = 4'd9;
    localparam op_t OP_MIN    = 4'd10;
    localparam op_t OP_MAX    = 4'd11;
    localparam op_t OP_PASS   = 4'd15;

endpackage

// File: rtl/mask_alu_lane.sv
// One channel of the mask ALU: purely combinational, shared mask applied to pixel p_i.
module mask_alu_lane
    import mask_proc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ALPHA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0]  p_i,
    input  logic [DATA_WIDTH-1:0]  m_i,
    input  logic                   mask_nz_i,
    input  op_t                    op_i,
    input  logic [ALPHA_WIDTH-1:0] alpha_i,
    output logic [DATA_WIDTH-1:0]  res_o
);

    localparam int unsigned BW = DATA_WIDTH + ALPHA_WIDTH + 1;

    logic [ALPHA_WIDTH:0]  inv_alpha;
    logic [BW-1:0]         blend_sum;
    logic [DATA_WIDTH-1:0] blend;
    logic [DATA_WIDTH:0]   add_sum;
    logic [DATA_WIDTH-1:0] all_ones;
    logic [DATA_WIDTH-1:0] mid_level;

    assign all_ones  = {DATA_WIDTH{1'b1}};
    assign mid_level = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    assign inv_alpha = {1'b1, {ALPHA_WIDTH{1'b0}}} - {1'b0, alpha_i};
    // Weights sum to 2^A, so the shifted blend always fits DATA_WIDTH.
    assign blend_sum = BW'(p_i) * BW'(inv_alpha) + BW'(m_i) * BW'(alpha_i);
    assign blend     = DATA_WIDTH'(blend_sum >> ALPHA_WIDTH);
    assign add_sum   = {1'b0, p_i} + {1'b0, m_i};

    always_comb begin
        res_o = p_i;
        case (op_i)
            OP_AND:    res_o = p_i & m_i;
            OP_OR:     res_o = p_i | m_i;
            OP_XOR:    res_o = p_i ^ m_i;
            OP_NOT:    res_o = ~p_i;
            OP_GATE:   res_o = mask_nz_i ? p_i : '0;
            OP_GATE_M: res_o = mask_nz_i ? p_i : mid_level;
            OP_THRESH: res_o = (p_i > m_i) ? all_ones : '0;
            OP_BLEND:  res_o = blend;
            OP_ADDS:   res_o = add_sum[DATA_WIDTH] ? all_ones : add_sum[DATA_WIDTH-1:0];
            OP_SUBS:   res_o = (p_i >= m_i) ? (p_i - m_i) : '0;
            OP_MIN:    res_o = (p_i < m_i) ? p_i : m_i;
            OP_MAX:    res_o = (p_i > m_i) ? p_i : m_i;
            default:   res_o = p_i;
        endcase
    end

endmodule

// File: rtl/mask_processor_mc.sv
// Two-stage multi-channel mask processor; op/alpha latch on start-of-frame beats.
// Optional MASK_PROCESSOR_MC_STATS_EN adds mask_count / last_mask_count outputs.
module mask_processor_mc
    import mask_proc_pkg::*;
#(
    parameter int unsigned CHANNELS    = 3,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned MASK_WIDTH  = 8,
    parameter int unsigned ALPHA_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_data,
    input  logic [MASK_WIDTH-1:0]          s_mask,
    input  logic                           s_sof,
    input  logic [3:0]                     op_cfg,
    input  logic [ALPHA_WIDTH-1:0]         alpha_cfg,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] m_data,
    output logic                           m_sof
`ifdef MASK_PROCESSOR_MC_STATS_EN
    ,
    output logic [31:0]                    mask_count,
    output logic [31:0]                    last_mask_count
`endif
);

    localparam int unsigned PW = CHANNELS * DATA_WIDTH;

    logic                   en;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  s_m;
    logic                   s_nz;
    logic [PW-1:0]          lane_res;

    op_t                    op_q, op_d;
    logic [ALPHA_WIDTH-1:0] alpha_q, alpha_d;

    logic                   s1_valid_q, s1_valid_d;
    logic [PW-1:0]          s1_data_q, s1_data_d;
    logic [DATA_WIDTH-1:0]  s1_m_q, s1_m_d;
    logic                   s1_nz_q, s1_nz_d;
    op_t                    s1_op_q, s1_op_d;
    logic [ALPHA_WIDTH-1:0] s1_alpha_q, s1_alpha_d;
    logic                   s1_sof_q, s1_sof_d;

    logic                   m_valid_q, m_valid_d;
    logic [PW-1:0]          m_data_q, m_data_d;
    logic                   m_sof_q, m_sof_d;

    assign en      = !m_valid_q || m_ready;
    assign s_ready = en;
    assign accept  = s_valid && en;
    assign s_nz    = (s_mask != '0);

    if (MASK_WIDTH >= DATA_WIDTH) begin : g_mask_trunc
        assign s_m = s_mask[DATA_WIDTH-1:0];
    end else begin : g_mask_ext
        assign s_m = {{(DATA_WIDTH-MASK_WIDTH){1'b0}}, s_mask};
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        mask_alu_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ALPHA_WIDTH(ALPHA_WIDTH)
        ) u_lane (
            .p_i      (s1_data_q[c*DATA_WIDTH +: DATA_WIDTH]),
            .m_i      (s1_m_q),
            .mask_nz_i(s1_nz_q),
            .op_i     (s1_op_q),
            .alpha_i  (s1_alpha_q),
            .res_o    (lane_res[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_comb begin
        op_d       = op_q;
        alpha_d    = alpha_q;
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_m_d     = s1_m_q;
        s1_nz_d    = s1_nz_q;
        s1_op_d    = s1_op_q;
        s1_alpha_d = s1_alpha_q;
        s1_sof_d   = s1_sof_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_sof_d    = m_sof_q;

        // The sof beat itself must already see the newly requested config.
        if (accept && s_sof) begin
            op_d    = op_cfg;
            alpha_d = alpha_cfg;
        end

        if (en) begin
            s1_valid_d = s_valid;
            if (accept) begin
                s1_data_d  = s_data;
                s1_m_d     = s_m;
                s1_nz_d    = s_nz;
                s1_op_d    = s_sof ? op_cfg : op_q;
                s1_alpha_d = s_sof ? alpha_cfg : alpha_q;
                s1_sof_d   = s_sof;
            end
            m_valid_d = s1_valid_q;
            m_sof_d   = s1_valid_q && s1_sof_q;
            if (s1_valid_q) begin
                m_data_d = lane_res;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= OP_PASS;
            alpha_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_m_q     <= '0;
            s1_nz_q    <= 1'b0;
            s1_op_q    <= OP_PASS;
            s1_alpha_q <= '0;
            s1_sof_q   <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_sof_q    <= 1'b0;
        end else begin
            op_q       <= op_d;
            alpha_q    <= alpha_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_m_q     <= s1_m_d;
            s1_nz_q    <= s1_nz_d;
            s1_op_q    <= s1_op_d;
            s1_alpha_q <= s1_alpha_d;
            s1_sof_q   <= s1_sof_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_sof_q    <= m_sof_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_sof   = m_sof_q;

`ifdef MASK_PROCESSOR_MC_STATS_EN
    logic [31:0] mask_count_q, mask_count_d;
    logic [31:0] last_mask_count_q, last_mask_count_d;

    always_comb begin
        mask_count_d      = mask_count_q;
        last_mask_count_d = last_mask_count_q;
        if (accept) begin
            if (s_sof) begin
                last_mask_count_d = mask_count_q;
                mask_count_d      = {31'd0, s_nz};
            end else if (s_nz && (mask_count_q != '1)) begin
                mask_count_d = mask_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_count_q      <= '0;
            last_mask_count_q <= '0;
        end else begin
            mask_count_q      <= mask_count_d;
            last_mask_count_q <= last_mask_count_d;
        end
    end

    assign mask_count      = mask_count_q;
    assign last_mask_count = last_mask_count_q;
`endif

endmodule

// File: tb/tb_mask_processor_mc.sv
// Scoreboard bench for mask_processor_mc: directed beats push expected results,
// a negedge monitor pops and compares each accepted output beat.
module tb_mask_processor_mc;

    localparam int unsigned CH = 3;
    localparam int unsigned DW = 8;
    localparam int unsigned MW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned PW = CH * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [PW-1:0] s_data = '0;
    logic [MW-1:0] s_mask = '0;
    logic          s_sof = 1'b0;
    logic [3:0]    op_cfg = '0;
    logic [AW-1:0] alpha_cfg = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [PW-1:0] m_data;
    logic          m_sof;
`ifdef MASK_PROCESSOR_MC_STATS_EN
    logic [31:0]   mask_count;
    logic [31:0]   last_mask_count;
`endif

    mask_processor_mc #(
        .CHANNELS   (CH),
        .DATA_WIDTH (DW),
        .MASK_WIDTH (MW),
        .ALPHA_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_mask   (s_mask),
        .s_sof    (s_sof),
        .op_cfg   (op_cfg),
        .alpha_cfg(alpha_cfg),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_sof    (m_sof)
`ifdef MASK_PROCESSOR_MC_STATS_EN
        ,
        .mask_count     (mask_count),
        .last_mask_count(last_mask_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] data;
        logic          sof;
        int            acc_cyc;
        bit            chk_lat;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    bit            prev_stall = 1'b0;
    logic [PW-1:0] prev_data;
    logic          prev_sof;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_data", m_data, prev_data);
                check("stall_valid", PW'(m_valid), PW'(1));
                check("stall_sof", PW'(m_sof), PW'(prev_sof));
            end
            if (m_valid && !m_ready) check("stall_s_ready", PW'(s_ready), PW'(0));
            if (m_valid && m_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %h required none", m_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("data", m_data, mon_e.data);
                    check("sof", PW'(m_sof), PW'(mon_e.sof));
                    if (mon_e.chk_lat) check("latency", PW'(cyc - mon_e.acc_cyc), PW'(2));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_sof   = m_sof;
        end
    end

    // Call at posedge+#1; returns at posedge+#1 after the beat was accepted.
    task automatic send(input logic [PW-1:0] d, input logic [MW-1:0] mk, input logic sof,
                        input logic [3:0] op, input logic [AW-1:0] al,
                        input logic [PW-1:0] exp_d, input bit chk_lat);
        int budget = 0;
        exp_t e;
        s_valid   = 1'b1;
        s_data    = d;
        s_mask    = mk;
        s_sof     = sof;
        op_cfg    = op;
        alpha_cfg = al;
        @(negedge clk);
        while (!s_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!s_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got s_ready=0 required 1");
        end else begin
            e.data    = exp_d;
            e.sof     = sof;
            e.acc_cyc = cyc;
            e.chk_lat = chk_lat;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while (sb_q.size() != 0 && b < 200) begin
            @(posedge clk);
            b++;
        end
        check("drain", PW'(sb_q.size()), PW'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", PW'(m_valid), PW'(0));
        check("rst_m_data", m_data, PW'(0));
        check("rst_m_sof", PW'(m_sof), PW'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("s_ready_after_rst", PW'(s_ready), PW'(1));
        @(posedge clk);
        #1;

        // Reset op is pass; op_cfg without sof must not take effect.
        send(24'h123456, 8'hFF, 1'b0, 4'd0, 4'd0, 24'h123456, 1'b1);
        // AND stream, back-to-back
        send(24'h5CAAF3, 8'h0F, 1'b1, 4'd0, 4'd0, 24'h0C0A03, 1'b1);
        send(24'h5CAAF3, 8'h0F, 1'b0, 4'd0, 4'd0, 24'h0C0A03, 1'b1);
        send(24'hF3F3F3, 8'h0F, 1'b0, 4'd0, 4'd0, 24'h030303, 1'b1);
        send(24'h00FF80, 8'h0F, 1'b0, 4'd0, 4'd0, 24'h000F00, 1'b1);
        send(24'h302010, 8'h0F, 1'b1, 4'd1, 4'd0, 24'h3F2F1F, 1'b1);
        send(24'h55F00F, 8'hFF, 1'b1, 4'd2, 4'd0, 24'hAA0FF0, 1'b1);
        send(24'h12FF00, 8'h00, 1'b1, 4'd3, 4'd0, 24'hED00FF, 1'b1);
        send(24'h112233, 8'h01, 1'b1, 4'd4, 4'd0, 24'h112233, 1'b1);
        send(24'h112233, 8'h00, 1'b0, 4'd4, 4'd0, 24'h000000, 1'b1);
        send(24'h112233, 8'h00, 1'b1, 4'd5, 4'd0, 24'h808080, 1'b1);
        send(24'h112233, 8'h02, 1'b0, 4'd5, 4'd0, 24'h112233, 1'b1);
        send(24'h008081, 8'h80, 1'b1, 4'd6, 4'd0, 24'h0000FF, 1'b1);
        send(24'hFF00C8, 8'h28, 1'b1, 4'd7, 4'd4, 24'hC90AA0, 1'b1);
        send(24'hFF00C8, 8'h28, 1'b1, 4'd7, 4'd0, 24'hFF00C8, 1'b1);
        send(24'hF505FA, 8'h0A, 1'b1, 4'd8, 4'd0, 24'hFF0FFF, 1'b1);
        send(24'h0AFA05, 8'h0A, 1'b1, 4'd9, 4'd0, 24'h00F000, 1'b1);
        send(24'h405030, 8'h40, 1'b1, 4'd10, 4'd0, 24'h404030, 1'b1);
        send(24'h405030, 8'h40, 1'b1, 4'd11, 4'd0, 24'h405040, 1'b1);
        send(24'hABCDEF, 8'hFF, 1'b1, 4'd12, 4'd0, 24'hABCDEF, 1'b1);
        // Mid-frame op change ignored until next sof
        send(24'h5CAAF3, 8'h0F, 1'b1, 4'd0, 4'd0, 24'h0C0A03, 1'b1);
        send(24'h5CAAF3, 8'h0F, 1'b0, 4'd6, 4'd0, 24'h0C0A03, 1'b1);
        send(24'h008081, 8'h80, 1'b1, 4'd6, 4'd0, 24'h0000FF, 1'b1);
        drain();

        // Backpressure: 5-cycle m_ready drop mid-stream, order must be preserved
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    send({8'(k + 8'h20), 8'(k + 8'h10), 8'(k)}, 8'hFF, (k == 0), 4'd0, 4'd0,
                         {8'(k + 8'h20), 8'(k + 8'h10), 8'(k)}, 1'b0);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 m_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 m_ready = 1'b1;
            end
        join
        drain();

        // Reset with beats in flight: nothing stale may come out afterwards
        send(24'h5CAAF3, 8'h0F, 1'b1, 4'd0, 4'd0, 24'h0C0A03, 1'b1);
        send(24'hF3F3F3, 8'h0F, 1'b0, 4'd0, 4'd0, 24'h030303, 1'b1);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("rst_mid_m_valid", PW'(m_valid), PW'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_idle", PW'(m_valid), PW'(0));
        end
        @(posedge clk);
        #1;
        send(24'h654321, 8'h0F, 1'b0, 4'd0, 4'd0, 24'h654321, 1'b1);
        drain();

`ifdef MASK_PROCESSOR_MC_STATS_EN
        begin
            logic [MW-1:0] masks [10];
            masks = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h00, 8'h04, 8'h00};
            for (int k = 0; k < 10; k++) begin
                send(24'h010203, masks[k], (k == 0), 4'd12, 4'd0, 24'h010203, 1'b1);
            end
            check("mask_count_frame", PW'(mask_count), PW'(4));
            send(24'h010203, 8'h00, 1'b1, 4'd12, 4'd0, 24'h010203, 1'b1);
            check("last_mask_count", PW'(last_mask_count), PW'(4));
            check("mask_count_restart", PW'(mask_count), PW'(0));
            drain();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
